gate_response_monitor: RTL and testbench

Hardware response checker for the two-input gate exercises. The stimulus side drives the four `{a,b}` combinations; this block observes each applied pair together with the gate's `out`, rebuilds the gate's truth table, and compares it against an expected table. It reports pass/fail, mismatch count, conflicts and timeout. It sits beside the gate under test as a synthesizable self-check and lets a bench or board confirm any gate assignment without waveform inspection.

---
 rtl/gate_response_monitor.sv | 112 +++++++++++
 tb/tb_gate_response_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_monitor.sv
// rtl/gate_response_monitor.sv - rebuilds a two-input gate truth table from observed samples and grades it
module gate_response_monitor #(
  parameter logic [3:0] EXP_TT  = 4'b0110,
  parameter int         TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       valid,
  input  logic       a,
  input  logic       b,
  input  logic       out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic       conflict,
  output logic [3:0] tt,
  output logic [3:0] seen,
  output logic [3:0] mismatch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  // idle counter compares against TIMEOUT-1 so done lands exactly TIMEOUT edges after the last sample
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] idle_cnt;

  logic [1:0] idx;
  logic [3:0] tt_upd;
  logic [3:0] seen_upd;
  logic       conflict_upd;
  logic [3:0] mis_upd;

  // results as they would look if the current sample were accepted
  always_comb begin
    idx          = {a, b};
    tt_upd       = tt;
    tt_upd[idx]  = out;
    seen_upd     = seen | (4'b0001 << idx);
    conflict_upd = conflict | (seen[idx] & (tt[idx] != out));
    mis_upd      = mismatch_cnt;
    if ((out != EXP_TT[idx]) && (mismatch_cnt != 4'hF)) begin
      mis_upd = mismatch_cnt + 4'd1;
    end
  end

  // capture state machine; every output is a register updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idle_cnt     <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      conflict     <= 1'b0;
      tt           <= 4'd0;
      seen         <= 4'd0;
      mismatch_cnt <= 4'd0;
    end else if (start) begin
      // start wins over a same-cycle valid; that sample is dropped
      state        <= S_CAPTURE;
      idle_cnt     <= 8'd0;
      busy         <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      conflict     <= 1'b0;
      tt           <= 4'd0;
      seen         <= 4'd0;
      mismatch_cnt <= 4'd0;
    end else begin
      case (state)
        S_CAPTURE: begin
          if (valid) begin
            tt           <= tt_upd;
            seen         <= seen_upd;
            conflict     <= conflict_upd;
            mismatch_cnt <= mis_upd;
            idle_cnt     <= 8'd0;
            if (seen_upd == 4'hF) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (tt_upd == EXP_TT) && !conflict_upd;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        default: begin
          // IDLE and DONE ignore valid; only start moves on
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_monitor.sv
// tb/tb_gate_response_monitor.sv - randomized self-check of gate_response_monitor against a transaction model
module tb_gate_response_monitor;

  localparam logic [3:0] EXP = 4'b0110;
  localparam int         TO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       out = 1'b0;
  logic       busy, done, pass, timeout, conflict;
  logic [3:0] tt, seen, mismatch_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int       g;
    bit [1:0] ab;
    bit       o;
  } smp_t;

  typedef struct {
    int       e;
    bit [1:0] ab;
    bit       o;
  } ap_t;

  smp_t q[$];

  gate_response_monitor #(.EXP_TT(EXP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid),
    .a(a), .b(b), .out(out),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .conflict(conflict), .tt(tt), .seen(seen), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int g, input bit [1:0] ab, input bit o);
    smp_t s;
    s.g = g; s.ab = ab; s.o = o;
    q.push_back(s);
  endtask

  task automatic do_start();
    start = 1'b1;
    valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  // model: walk the sample list with the table/coverage/gap rules, then drive and compare
  task automatic run_capture(input string name);
    bit       t[4];
    bit       s[4];
    int       mis, p, e, done_e, k;
    bit       conf, to_hit, full, early;
    bit [3:0] m_tt, m_seen, m_mis;
    bit       m_pass;
    ap_t      aq[$];
    ap_t      ap;

    for (int i = 0; i < 4; i++) begin t[i] = 0; s[i] = 0; end
    mis = 0; conf = 0; to_hit = 0; p = 0; done_e = -1;
    for (int i = 0; i < q.size() && done_e < 0; i++) begin
      if (q[i].g >= TO) begin
        done_e = p + TO;
        to_hit = 1;
      end else begin
        e = p + q[i].g + 1;
        if (s[q[i].ab] && t[q[i].ab] != q[i].o) conf = 1;
        t[q[i].ab] = q[i].o;
        s[q[i].ab] = 1;
        if (q[i].o != EXP[q[i].ab]) mis++;
        ap.e = e; ap.ab = q[i].ab; ap.o = q[i].o;
        aq.push_back(ap);
        full = s[0] && s[1] && s[2] && s[3];
        if (full) done_e = e;
        p = e;
      end
    end
    if (done_e < 0) begin
      done_e = p + TO;
      to_hit = 1;
    end
    for (int i = 0; i < 4; i++) begin m_tt[i] = t[i]; m_seen[i] = s[i]; end
    m_mis  = (mis > 15) ? 4'd15 : 4'(mis);
    m_pass = !to_hit && !conf && (m_tt == EXP);

    do_start();
    check({name, ".start_busy"}, busy, 1);
    check({name, ".start_seen"}, seen, 0);

    early = 0;
    k = 0;
    for (int c = 1; c <= done_e; c++) begin
      if (k < aq.size() && aq[k].e == c) begin
        valid = 1'b1;
        {a, b} = aq[k].ab;
        out = aq[k].o;
        k++;
      end else begin
        valid = 1'b0;
        {a, b} = 2'($urandom_range(0, 3));
        out = 1'($urandom_range(0, 1));
      end
      step();
      valid = 1'b0;
      if (c < done_e && done) early = 1;
    end

    check({name, ".early_done"}, early, 0);
    check({name, ".done"}, done, 1);
    check({name, ".busy"}, busy, 0);
    check({name, ".pass"}, pass, m_pass);
    check({name, ".timeout"}, timeout, to_hit);
    check({name, ".conflict"}, conflict, conf);
    check({name, ".tt"}, tt, m_tt);
    check({name, ".seen"}, seen, m_seen);
    check({name, ".mismatch"}, mismatch_cnt, m_mis);

    // DONE must hold results while valid keeps arriving
    for (int c = 0; c < 3; c++) begin
      valid = 1'b1;
      {a, b} = 2'($urandom_range(0, 3));
      out = 1'($urandom_range(0, 1));
      step();
    end
    valid = 1'b0;
    check({name, ".hold"}, {28'd0, done, pass, timeout, conflict}, {28'd0, 1'b1, m_pass, to_hit, conf});
    check({name, ".hold_tt"}, {tt, seen, mismatch_cnt}, {m_tt, m_seen, m_mis});
    q.delete();
  endtask

  initial begin
    int n, r, g;

    repeat (2) step();
    check("reset", {busy, done, pass, timeout, conflict, tt, seen, mismatch_cnt}, 0);
    rst_n = 1'b1;
    step();
    check("idle_after_reset", {busy, done}, 0);

    add(0, 2'b00, 0); add(0, 2'b01, 1); add(0, 2'b10, 1); add(0, 2'b11, 0);
    run_capture("xor");

    add(0, 2'b00, 0); add(0, 2'b01, 0); add(0, 2'b10, 0); add(0, 2'b11, 1);
    run_capture("and");

    add(0, 2'b00, 0); add(0, 2'b00, 1); add(0, 2'b01, 1); add(0, 2'b10, 1); add(0, 2'b11, 0);
    run_capture("conflict");

    add(0, 2'b00, 0); add(0, 2'b01, 1);
    run_capture("timeout");

    add(TO - 1, 2'b00, 0); add(TO - 1, 2'b01, 1); add(0, 2'b10, 1); add(TO, 2'b11, 0);
    run_capture("gap_edge");

    for (int i = 0; i < 17; i++) add(0, 2'b00, 1);
    add(0, 2'b01, 1); add(0, 2'b10, 1); add(0, 2'b11, 0);
    run_capture("saturate");

    // reset between edges mid-capture must clear outputs immediately
    do_start();
    valid = 1'b1; {a, b} = 2'b00; out = 1'b0; step();
    {a, b} = 2'b01; out = 1'b1; step();
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", {busy, done, pass, timeout, conflict, tt, seen, mismatch_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    add(0, 2'b11, 0); add(0, 2'b10, 1); add(0, 2'b01, 1); add(0, 2'b00, 0);
    run_capture("after_reset");

    // start and valid together: sample dropped
    start = 1'b1; valid = 1'b1; {a, b} = 2'b10; out = 1'b1;
    step();
    start = 1'b0; valid = 1'b0;
    check("start_prio_seen", seen, 0);
    check("start_prio_busy", busy, 1);

    for (int run = 0; run < 40; run++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)       g = 0;
        else if (r < 8)  g = $urandom_range(1, 4);
        else if (r == 8) g = TO - 1;
        else             g = TO;
        add(g, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      run_capture($sformatf("rnd%0d", run));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
